bsg_manycore_npa_req_launcher: RTL



---
 rtl/bsg_manycore_pkg.sv | 27 ++
 rtl/bsg_manycore_launch_fifo.sv | 57 +++++
 rtl/bsg_manycore_npa_req_launcher.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bsg_manycore_pkg.sv
// Shared types for the manycore remote-request launch path.
// The queue entry is width-dependent, so it is declared per instance by macro.
package bsg_manycore_pkg;

    typedef enum logic [1:0] {
        e_launch_load     = 2'd0,
        e_launch_store    = 2'd1,
        e_launch_amo_swap = 2'd2,
        e_launch_amo_add  = 2'd3
    } bsg_manycore_launch_op_e;

    localparam int eva_width_gp = 32;

endpackage

`define DECLARE_BSG_MANYCORE_LAUNCH_ENTRY_S(x_w, y_w, a_w, d_w, r_w) \
    typedef struct packed {                  \
        logic [x_w-1:0]          x;          \
        logic [y_w-1:0]          y;          \
        logic [a_w-1:0]          epa;        \
        logic [d_w-1:0]          data;       \
        logic [(d_w/8)-1:0]      mask;       \
        bsg_manycore_launch_op_e op;         \
        logic [r_w-1:0]          reg_id;     \
        logic [x_w-1:0]          src_x;      \
        logic [y_w-1:0]          src_y;      \
    } bsg_manycore_launch_entry_s

// File: rtl/bsg_manycore_launch_fifo.sv
// Two-entry FIFO with asynchronous active-low reset.
// ready_o comes straight from the registered occupancy, never from yumi_i.
module bsg_manycore_launch_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_q [2];
    logic [width_p-1:0] mem_d [2];
    logic               wptr_q, wptr_d;
    logic               rptr_q, rptr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               enq, deq;

    assign ready_o = (cnt_q != 2'd2);
    assign v_o     = (cnt_q != 2'd0);
    assign data_o  = mem_q[rptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (enq) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = ~wptr_q;
        end
        if (deq) begin
            rptr_d = ~rptr_q;
        end
        cnt_d = cnt_q + 2'(enq) - 2'(deq);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q  <= '{default: '0};
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/bsg_manycore_npa_req_launcher.sv
// Remote-request launcher: queues translated requests, meters them with credits
// and turns untranslatable addresses into a sticky fault.
module bsg_manycore_npa_req_launcher
    import bsg_manycore_pkg::*;
#(
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int addr_width_p      = 16,
    parameter int data_width_p      = 32,
    parameter int max_out_credits_p = 16,
    parameter int reg_id_width_p    = 5
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [x_cord_width_p-1:0]              my_x_i,
    input  logic [y_cord_width_p-1:0]              my_y_i,
    input  logic                                   npa_v_i,
    output logic                                   npa_ready_o,
    input  logic [x_cord_width_p-1:0]              npa_x_i,
    input  logic [y_cord_width_p-1:0]              npa_y_i,
    input  logic [addr_width_p-1:0]                npa_epa_i,
    input  logic                                   npa_invalid_i,
    input  logic [eva_width_gp-1:0]                npa_eva_i,
    input  logic [1:0]                             op_i,
    input  logic [data_width_p-1:0]                data_i,
    input  logic [(data_width_p/8)-1:0]            mask_i,
    input  logic [reg_id_width_p-1:0]              reg_id_i,
    output logic                                   pkt_v_o,
    input  logic                                   pkt_ready_i,
    output logic [x_cord_width_p-1:0]              pkt_x_o,
    output logic [y_cord_width_p-1:0]              pkt_y_o,
    output logic [addr_width_p-1:0]                pkt_addr_o,
    output logic [data_width_p-1:0]                pkt_data_o,
    output logic [(data_width_p/8)-1:0]            pkt_mask_o,
    output logic [1:0]                             pkt_op_o,
    output logic [reg_id_width_p-1:0]              pkt_reg_id_o,
    output logic [x_cord_width_p-1:0]              pkt_src_x_o,
    output logic [y_cord_width_p-1:0]              pkt_src_y_o,
    input  logic                                   credit_return_i,
    output logic [$clog2(max_out_credits_p+1)-1:0] out_credits_o,
    output logic                                   fence_busy_o,
    output logic                                   fault_o,
    output logic [eva_width_gp-1:0]                fault_eva_o,
    input  logic                                   fault_clear_i
);

    `DECLARE_BSG_MANYCORE_LAUNCH_ENTRY_S(x_cord_width_p, y_cord_width_p,
        addr_width_p, data_width_p, reg_id_width_p);

    localparam int entry_width_lp  = $bits(bsg_manycore_launch_entry_s);
    localparam int credit_width_lp = $clog2(max_out_credits_p + 1);
    localparam logic [credit_width_lp-1:0] max_credits_lp =
        credit_width_lp'(max_out_credits_p);
    localparam logic [credit_width_lp-1:0] one_lp = credit_width_lp'(1);

    bsg_manycore_launch_entry_s enq_entry, head_entry;
    logic [entry_width_lp-1:0]  head_bits;

    logic                       fifo_ready, fifo_v;
    logic                       hs, enq, deq, fault_set;

    logic [credit_width_lp-1:0] credits_q, credits_d;
    logic                       fence_busy_q, fence_busy_d;
    logic                       fault_q, fault_d;
    logic [eva_width_gp-1:0]    fault_eva_q, fault_eva_d;
    logic                       armed_q, armed_d;

    // armed_q holds ready low until the first edge after reset release
    assign npa_ready_o = armed_q & fifo_ready & (credits_q != '0) & ~fault_q;
    assign hs          = npa_v_i & npa_ready_o;
    assign enq         = hs & ~npa_invalid_i;
    assign fault_set   = hs & npa_invalid_i;
    assign deq         = fifo_v & pkt_ready_i;

    always_comb begin
        enq_entry        = '0;
        enq_entry.x      = npa_x_i;
        enq_entry.y      = npa_y_i;
        enq_entry.epa    = npa_epa_i;
        enq_entry.data   = data_i;
        enq_entry.mask   = mask_i;
        enq_entry.op     = bsg_manycore_launch_op_e'(op_i);
        enq_entry.reg_id = reg_id_i;
        enq_entry.src_x  = my_x_i;
        enq_entry.src_y  = my_y_i;
    end

    bsg_manycore_launch_fifo #(
        .width_p (entry_width_lp)
    ) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (enq),
        .data_i    (enq_entry),
        .ready_o   (fifo_ready),
        .v_o       (fifo_v),
        .data_o    (head_bits),
        .yumi_i    (deq)
    );

    assign head_entry   = bsg_manycore_launch_entry_s'(head_bits);
    assign pkt_v_o      = fifo_v;
    assign pkt_x_o      = head_entry.x;
    assign pkt_y_o      = head_entry.y;
    assign pkt_addr_o   = head_entry.epa;
    assign pkt_data_o   = head_entry.data;
    assign pkt_mask_o   = head_entry.mask;
    assign pkt_op_o     = head_entry.op;
    assign pkt_reg_id_o = head_entry.reg_id;
    assign pkt_src_x_o  = head_entry.src_x;
    assign pkt_src_y_o  = head_entry.src_y;

    // Credits are consumed at accept, so buffered entries count as outstanding
    always_comb begin
        credits_d = credits_q;
        if (enq & ~credit_return_i) begin
            credits_d = credits_q - one_lp;
        end else if (credit_return_i & ~enq & (credits_q != max_credits_lp)) begin
            credits_d = credits_q + one_lp;
        end
        fence_busy_d = (credits_d != max_credits_lp);
    end

    always_comb begin
        fault_d     = fault_q;
        fault_eva_d = fault_eva_q;
        armed_d     = 1'b1;
        if (fault_clear_i) begin
            fault_d = 1'b0;
        end
        if (fault_set) begin
            fault_d     = 1'b1;
            fault_eva_d = npa_eva_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_q    <= max_credits_lp;
            fence_busy_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_eva_q  <= '0;
            armed_q      <= 1'b0;
        end else begin
            credits_q    <= credits_d;
            fence_busy_q <= fence_busy_d;
            fault_q      <= fault_d;
            fault_eva_q  <= fault_eva_d;
            armed_q      <= armed_d;
        end
    end

    assign out_credits_o = credits_q;
    assign fence_busy_o  = fence_busy_q;
    assign fault_o       = fault_q;
    assign fault_eva_o   = fault_eva_q;

    credit_overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(credit_return_i && (credits_q == max_credits_lp)));

endmodule
